udp_tx_mux_lookup: RTL and testbench

UDP_TX_MUX_LOOKUP -- requirements
Module: udp_tx_mux_lookup

---
 rtl/udp_tx_mux_lookup.sv | 243 ++++++++++++++++++++++++
 tb/tb_udp_tx_mux_lookup.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_mux_lookup.sv
// udp_tx_mux_lookup: round-robin multiplexer of NUM_CHANNELS UDP TX streams
// onto one output stream. Before each packet is forwarded, its connection id is
// resolved through an external lookup. A hit forwards the packet with the
// destination metadata. A miss drains the packet and drops it.
// Optional feature macro: UDP_TX_DROP_CNT_EN. When it is defined, drop_count
// is a saturating counter of missed packets. When it is undefined, drop_count
// is tied to 0 and no counter register is built.
//
// Handshake semantics on every stream and lookup port: a transfer happens on
// the rising clock edge where valid && ready are both high. Once a producer
// raises valid, it holds valid and its payload stable until the transfer
// happens. A consumer may raise or drop ready at any time.
module udp_tx_mux_lookup #(
    parameter int NUM_CHANNELS   = 4,
    parameter int DATA_WIDTH     = 512,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int CONN_ID_WIDTH  = 18,
    parameter int DROP_CNT_WIDTH = 32,
    localparam int CH_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                  tx_axis_aclk,
    input  logic                                  tx_axis_areset,
    input  logic [NUM_CHANNELS-1:0]               udp_tx_axis_tvalid,
    input  logic [NUM_CHANNELS-1:0]               udp_tx_axis_tlast,
    output logic [NUM_CHANNELS-1:0]               udp_tx_axis_tready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    udp_tx_axis_tdata,
    input  logic [NUM_CHANNELS*KEEP_WIDTH-1:0]    udp_tx_axis_tkeep,
    input  logic [NUM_CHANNELS*CONN_ID_WIDTH-1:0] udp_tx_axis_connection_id,
    output logic                                  m01_axis_rv_lookup_valid,
    output logic [CONN_ID_WIDTH-1:0]              m01_axis_rv_lookup_connectionId,
    input  logic                                  m01_axis_rv_lookup_ready,
    input  logic                                  s01_axis_rv_lookup_valid,
    input  logic                                  s01_axis_rv_lookup_hit,
    input  logic [47:0]                           s01_axis_rv_lookup_macAddr,
    input  logic [31:0]                           s01_axis_rv_lookup_ipAddr,
    input  logic [15:0]                           s01_axis_rv_lookup_udpPort,
    output logic                                  s01_axis_rv_lookup_ready,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast,
    input  logic                                  m_axis_tready,
    output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]                 m_axis_tkeep,
    output logic [47:0]                           m_axis_dst_macAddr,
    output logic [31:0]                           m_axis_dst_ipAddr,
    output logic [15:0]                           m_axis_dst_udpPort,
    output logic [CH_W-1:0]                       m_axis_channel,
    output logic [DROP_CNT_WIDTH-1:0]             drop_count,
    output logic [2:0]                            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_FWD  = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [CH_W-1:0]          grant_q, grant_d;
    logic [CH_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]          chan_q, chan_d;
    logic [CONN_ID_WIDTH-1:0] id_q, id_d;
    logic [47:0]              mac_q, mac_d;
    logic [31:0]              ip_q, ip_d;
    logic [15:0]              port_q, port_d;

    logic                     arb_found;
    logic [CH_W-1:0]          arb_idx;
    logic [CONN_ID_WIDTH-1:0] arb_id;
    logic                     g_valid, g_last, g_ready;
    logic [DATA_WIDTH-1:0]    g_data;
    logic [KEEP_WIDTH-1:0]    g_keep;
    logic [CH_W-1:0]          next_ptr;
    logic                     drop_done;

    // Round-robin pick: the first valid channel at or above rr_ptr wins. If
    // there is none, the lowest valid channel wins (the search wraps).
    always_comb begin
        logic            hi_found, lo_found;
        logic [CH_W-1:0] hi_idx, lo_idx;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        arb_id   = '0;
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            if (udp_tx_axis_tvalid[c]) begin
                lo_found = 1'b1;
                lo_idx   = CH_W'(c);
                if (CH_W'(c) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = CH_W'(c);
                end
            end
        end
        arb_found = lo_found;
        arb_idx   = hi_found ? hi_idx : lo_idx;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (arb_idx == CH_W'(c)) begin
                arb_id = udp_tx_axis_connection_id[c*CONN_ID_WIDTH +: CONN_ID_WIDTH];
            end
        end
    end

    // Select the granted channel's stream and route its ready back to it.
    always_comb begin
        g_valid            = 1'b0;
        g_last             = 1'b0;
        g_data             = '0;
        g_keep             = '0;
        udp_tx_axis_tready = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (grant_q == CH_W'(c)) begin
                g_valid               = udp_tx_axis_tvalid[c];
                g_last                = udp_tx_axis_tlast[c];
                g_data                = udp_tx_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH];
                g_keep                = udp_tx_axis_tkeep[c*KEEP_WIDTH +: KEEP_WIDTH];
                udp_tx_axis_tready[c] = g_ready;
            end
        end
    end

    assign next_ptr = (grant_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant_q + CH_W'(1);

    // Packet FSM next state plus per-state handshake outputs.
    always_comb begin
        state_d                  = state_q;
        grant_d                  = grant_q;
        rr_ptr_d                 = rr_ptr_q;
        chan_d                   = chan_q;
        id_d                     = id_q;
        mac_d                    = mac_q;
        ip_d                     = ip_q;
        port_d                   = port_q;
        m01_axis_rv_lookup_valid = 1'b0;
        s01_axis_rv_lookup_ready = 1'b0;
        m_axis_tvalid            = 1'b0;
        g_ready                  = 1'b0;
        drop_done                = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    id_d    = arb_id;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                m01_axis_rv_lookup_valid = 1'b1;
                if (m01_axis_rv_lookup_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                s01_axis_rv_lookup_ready = 1'b1;
                if (s01_axis_rv_lookup_valid) begin
                    if (s01_axis_rv_lookup_hit) begin
                        // Metadata and channel move only when a forward begins.
                        mac_d   = s01_axis_rv_lookup_macAddr;
                        ip_d    = s01_axis_rv_lookup_ipAddr;
                        port_d  = s01_axis_rv_lookup_udpPort;
                        chan_d  = grant_q;
                        state_d = S_FWD;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end
            S_FWD: begin
                m_axis_tvalid = g_valid;
                g_ready       = m_axis_tready;
                if (g_valid && m_axis_tready && g_last) begin
                    rr_ptr_d = next_ptr;
                    state_d  = S_IDLE;
                end
            end
            S_DROP: begin
                g_ready = 1'b1;
                if (g_valid && g_last) begin
                    drop_done = 1'b1;
                    rr_ptr_d  = next_ptr;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and packet-context registers.
    always_ff @(posedge tx_axis_aclk or posedge tx_axis_areset) begin
        if (tx_axis_areset) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            chan_q   <= '0;
            id_q     <= '0;
            mac_q    <= '0;
            ip_q     <= '0;
            port_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            chan_q   <= chan_d;
            id_q     <= id_d;
            mac_q    <= mac_d;
            ip_q     <= ip_d;
            port_q   <= port_d;
        end
    end

`ifdef UDP_TX_DROP_CNT_EN
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

    // Saturating count of packets dropped on a lookup miss.
    always_ff @(posedge tx_axis_aclk or posedge tx_axis_areset) begin
        if (tx_axis_areset) begin
            drop_cnt_q <= '0;
        end else if (drop_done && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + DROP_CNT_WIDTH'(1);
        end
    end

    assign drop_count = drop_cnt_q;
`else
    logic unused_drop_done;
    assign unused_drop_done = drop_done;
    assign drop_count       = '0;
`endif

    // The output beat is zero outside FWD, so nothing leaks while idle or dropping.
    assign m_axis_tdata                    = (state_q == S_FWD) ? g_data : '0;
    assign m_axis_tkeep                    = (state_q == S_FWD) ? g_keep : '0;
    assign m_axis_tlast                    = (state_q == S_FWD) ? g_last : 1'b0;
    assign m01_axis_rv_lookup_connectionId = id_q;
    assign m_axis_dst_macAddr              = mac_q;
    assign m_axis_dst_ipAddr               = ip_q;
    assign m_axis_dst_udpPort              = port_q;
    assign m_axis_channel                  = chan_q;
    assign dbg_state                       = state_q;

endmodule

// File: tb/tb_udp_tx_mux_lookup.sv
// Testbench for udp_tx_mux_lookup. It uses randomized packet traffic. A
// packet-level round-robin model plus a lookup table predicts the request
// ids, the output beats and the drop count.
module tb_udp_tx_mux_lookup;

    localparam int NCH = 4;
    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int IDW = 18;
    localparam int DCW = 3;
    localparam int CHW = 2;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [KW-1:0]  keep;
        logic           last;
        logic [IDW-1:0] id;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [KW-1:0]  keep;
        logic           last;
        logic [CHW-1:0] chan;
        logic [47:0]    mac;
        logic [31:0]    ip;
        logic [15:0]    port;
    } obeat_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NCH-1:0]     tvalid, tlast, tready;
    logic [NCH*DW-1:0]  tdata;
    logic [NCH*KW-1:0]  tkeep;
    logic [NCH*IDW-1:0] conn_id;
    logic               m01_valid, m01_ready;
    logic [IDW-1:0]     m01_id;
    logic               s01_valid, s01_hit, s01_ready;
    logic [47:0]        s01_mac;
    logic [31:0]        s01_ip;
    logic [15:0]        s01_port;
    logic               m_tvalid, m_tlast, m_tready;
    logic [DW-1:0]      m_tdata;
    logic [KW-1:0]      m_tkeep;
    logic [47:0]        m_mac;
    logic [31:0]        m_ip;
    logic [15:0]        m_port;
    logic [CHW-1:0]     m_chan;
    logic [DCW-1:0]     drop_count;
    logic [2:0]         dbg_state;

    udp_tx_mux_lookup #(
        .NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
        .CONN_ID_WIDTH(IDW), .DROP_CNT_WIDTH(DCW)
    ) dut (
        .tx_axis_aclk(clk),
        .tx_axis_areset(rst),
        .udp_tx_axis_tvalid(tvalid),
        .udp_tx_axis_tlast(tlast),
        .udp_tx_axis_tready(tready),
        .udp_tx_axis_tdata(tdata),
        .udp_tx_axis_tkeep(tkeep),
        .udp_tx_axis_connection_id(conn_id),
        .m01_axis_rv_lookup_valid(m01_valid),
        .m01_axis_rv_lookup_connectionId(m01_id),
        .m01_axis_rv_lookup_ready(m01_ready),
        .s01_axis_rv_lookup_valid(s01_valid),
        .s01_axis_rv_lookup_hit(s01_hit),
        .s01_axis_rv_lookup_macAddr(s01_mac),
        .s01_axis_rv_lookup_ipAddr(s01_ip),
        .s01_axis_rv_lookup_udpPort(s01_port),
        .s01_axis_rv_lookup_ready(s01_ready),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast),
        .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep),
        .m_axis_dst_macAddr(m_mac),
        .m_axis_dst_ipAddr(m_ip),
        .m_axis_dst_udpPort(m_port),
        .m_axis_channel(m_chan),
        .drop_count(drop_count),
        .dbg_state(dbg_state)
    );

    // model / scoreboard state
    beat_t          ch_q[NCH][$];
    obeat_t         exp_q[$];
    logic [IDW-1:0] exp_req_q[$];
    logic [IDW-1:0] resp_q[$];
    bit             first_beat[NCH];
    int             model_ptr = 0;
    int             misses_total = 0;
    int             vectors = 0;
    int             miscompares = 0;
    int             beats_seen = 0;
    int             cyc = 0;
    int             first_out_cyc = -1;
    // stimulus knobs
    int             stall_pct = 0;
    int             m01_low_pct = 0;
    int             resp_delay_pct = 0;
    int             tready_mode = 0;  // 0 always, 1 toggle, 2 random
    bit             m01_hold5 = 1'b0;
    int             m01_wait_cnt = 0;
    bit             toggle = 1'b0;
    bit             req_pend = 1'b0;
    logic [IDW-1:0] req_id_prev = '0;

    // lookup table of the responder
    function automatic bit lk_hit(logic [IDW-1:0] id);
        return id[1:0] != 2'b11;
    endfunction
    function automatic logic [47:0] lk_mac(logic [IDW-1:0] id);
        return (id == IDW'(5)) ? 48'h0A0B0C0D0E0F : {30'h15555, id};
    endfunction
    function automatic logic [31:0] lk_ip(logic [IDW-1:0] id);
        return {14'h3000, id};
    endfunction
    function automatic logic [15:0] lk_port(logic [IDW-1:0] id);
        return id[15:0] ^ 16'hA5A5;
    endfunction

    function automatic logic [DCW-1:0] exp_drop();
`ifdef UDP_TX_DROP_CNT_EN
        return (misses_total > 7) ? DCW'(7) : DCW'(misses_total);
`else
        return '0;
`endif
    endfunction

    function automatic bit all_done();
        bit d;
        d = (exp_q.size() == 0) && (exp_req_q.size() == 0) && (resp_q.size() == 0);
        for (int c = 0; c < NCH; c++) if (ch_q[c].size() != 0) d = 1'b0;
        return d;
    endfunction

    // Beats after the first one carry a junk id unless same_id is set,
    // because only the first beat's id may be used.
    task automatic add_packet(int c, int nbeats, logic [IDW-1:0] id, bit same_id);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = KW'($urandom);
            b.last = (i == nbeats - 1);
            b.id   = (i == 0 || same_id) ? id : IDW'($urandom);
            ch_q[c].push_back(b);
        end
    endtask

    // Packet-level model: all queued packets are pending, granted round-robin
    // one whole packet at a time, then forwarded on a hit or dropped on a miss.
    task automatic build_model();
        int             pos[NCH];
        int             c;
        bit             found;
        logic [IDW-1:0] id;
        beat_t          b;
        obeat_t         o;
        for (int i = 0; i < NCH; i++) pos[i] = 0;
        forever begin
            found = 1'b0;
            c = 0;
            for (int k = 0; k < NCH; k++) begin
                int cc;
                cc = (model_ptr + k) % NCH;
                if (!found && pos[cc] < ch_q[cc].size()) begin
                    found = 1'b1;
                    c = cc;
                end
            end
            if (!found) break;
            id = ch_q[c][pos[c]].id;
            exp_req_q.push_back(id);
            do begin
                b = ch_q[c][pos[c]];
                pos[c]++;
                if (lk_hit(id)) begin
                    o.data = b.data; o.keep = b.keep; o.last = b.last; o.chan = CHW'(c);
                    o.mac = lk_mac(id); o.ip = lk_ip(id); o.port = lk_port(id);
                    exp_q.push_back(o);
                end
            end while (!b.last && pos[c] < ch_q[c].size());
            if (!lk_hit(id)) misses_total++;
            model_ptr = (c + 1) % NCH;
        end
    endtask

    // driver: applied just after the falling edge
    logic [NCH-1:0] valid_drv;
    task automatic drive_inputs();
        for (int c = 0; c < NCH; c++) begin
            if (ch_q[c].size() > 0 && (first_beat[c] || $urandom_range(99) >= stall_pct)) begin
                valid_drv[c] = 1'b1;
                tdata[c*DW +: DW]     = ch_q[c][0].data;
                tkeep[c*KW +: KW]     = ch_q[c][0].keep;
                tlast[c]              = ch_q[c][0].last;
                conn_id[c*IDW +: IDW] = ch_q[c][0].id;
            end else begin
                valid_drv[c] = 1'b0;
                tdata[c*DW +: DW]     = {$urandom, $urandom};
                tkeep[c*KW +: KW]     = KW'($urandom);
                tlast[c]              = 1'($urandom);
                conn_id[c*IDW +: IDW] = IDW'($urandom);
            end
        end
        tvalid = valid_drv;
        m01_ready = m01_hold5 ? (m01_wait_cnt >= 5) : ($urandom_range(99) >= m01_low_pct);
        if (resp_q.size() > 0 && $urandom_range(99) >= resp_delay_pct) begin
            s01_valid = 1'b1;
            s01_hit   = lk_hit(resp_q[0]);
            s01_mac   = lk_mac(resp_q[0]);
            s01_ip    = lk_ip(resp_q[0]);
            s01_port  = lk_port(resp_q[0]);
        end else begin
            s01_valid = 1'b0;
            s01_hit   = 1'($urandom);
            s01_mac   = {$urandom, 16'($urandom)};
            s01_ip    = $urandom;
            s01_port  = 16'($urandom);
        end
        toggle = ~toggle;
        case (tready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = toggle;
            default: m_tready = 1'($urandom_range(1));
        endcase
    endtask

    // Sample shortly before the rising edge. The handshakes seen here are the
    // ones that complete on that edge.
    task automatic observe();
        beat_t          b;
        obeat_t         e;
        logic [IDW-1:0] eid;
        if ($countones(tready) > 1) begin
            miscompares++;
            $display("FAIL tready_onehot: got %b required at most one bit", tready);
        end
        for (int c = 0; c < NCH; c++) begin
            if (valid_drv[c] && tready[c]) begin
                b = ch_q[c].pop_front();
                first_beat[c] = b.last;
            end
        end
        if (req_pend) begin
            vectors++;
            if (!(m01_valid === 1'b1 && m01_id === req_id_prev)) begin
                miscompares++;
                $display("FAIL req_stable: got valid=%b id=%h required valid=1 id=%h", m01_valid, m01_id, req_id_prev);
            end
        end
        req_pend    = m01_valid && !m01_ready;
        req_id_prev = m01_id;
        if (m01_valid) m01_wait_cnt++;
        if (m01_valid && m01_ready) begin
            vectors++;
            m01_wait_cnt = 0;
            if (exp_req_q.size() == 0) begin
                miscompares++;
                $display("FAIL req_id: got unexpected request id=%h required none", m01_id);
            end else begin
                eid = exp_req_q.pop_front();
                if (m01_id !== eid) begin
                    miscompares++;
                    $display("FAIL req_id: got %h required %h", m01_id, eid);
                end
            end
            resp_q.push_back(m01_id);
        end
        if (s01_valid && s01_ready) void'(resp_q.pop_front());
        if (m_tvalid && exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL out_valid: got m_axis_tvalid=1 required 0 (no beat expected)");
        end else if (m_tvalid && m_tready) begin
            vectors++;
            beats_seen++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            e = exp_q.pop_front();
            if (m_tdata !== e.data || m_tkeep !== e.keep || m_tlast !== e.last) begin
                miscompares++;
                $display("FAIL out_beat: got data=%h keep=%h last=%b required data=%h keep=%h last=%b",
                         m_tdata, m_tkeep, m_tlast, e.data, e.keep, e.last);
            end
            if (m_chan !== e.chan || m_mac !== e.mac || m_ip !== e.ip || m_port !== e.port) begin
                miscompares++;
                $display("FAIL out_meta: got ch=%0d mac=%h ip=%h port=%h required ch=%0d mac=%h ip=%h port=%h",
                         m_chan, m_mac, m_ip, m_port, e.chan, e.mac, e.ip, e.port);
            end
        end
    endtask

    task automatic cycle();
        drive_inputs();
        #4;
        observe();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Runs until the traffic drains, or (stop_beats >= 0) until that many output beats.
    task automatic run(int max_cycles, int stop_beats, string name);
        int n;
        n = 0;
        while (n < max_cycles) begin
            if (stop_beats >= 0 && beats_seen >= stop_beats) break;
            if (stop_beats < 0 && all_done()) break;
            cycle();
            n++;
        end
        if (n >= max_cycles) begin
            miscompares++;
            $display("FAIL %s_timeout: got no completion after %0d cycles required completion", name, n);
        end
        if (stop_beats < 0) begin
            cycle();
            cycle();
        end
    endtask

    task automatic end_check(string name);
        vectors++;
        if (drop_count !== exp_drop()) begin
            miscompares++;
            $display("FAIL %s_drop: got %0d required %0d", name, drop_count, exp_drop());
        end
        vectors++;
        if (dut.rr_ptr_q !== CHW'(model_ptr)) begin
            miscompares++;
            $display("FAIL %s_rr_ptr: got %0d required %0d", name, dut.rr_ptr_q, model_ptr);
        end
        vectors++;
        if (dbg_state !== 3'd0 || m_tvalid !== 1'b0 || tready !== '0) begin
            miscompares++;
            $display("FAIL %s_idle: got state=%0d tvalid=%b tready=%b required 0/0/0", name, dbg_state, m_tvalid, tready);
        end
    endtask

    task automatic check_reset_outputs(string name);
        vectors++;
        if (tready !== '0 || m_tvalid !== 1'b0 || m01_valid !== 1'b0 || s01_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_handshake: got tready=%b tvalid=%b m01v=%b s01r=%b required all 0",
                     name, tready, m_tvalid, m01_valid, s01_ready);
        end
        vectors++;
        if (m_mac !== '0 || m_ip !== '0 || m_port !== '0 || m_chan !== '0) begin
            miscompares++;
            $display("FAIL %s_meta: got mac=%h ip=%h port=%h ch=%0d required 0", name, m_mac, m_ip, m_port, m_chan);
        end
        vectors++;
        if (drop_count !== '0 || dbg_state !== 3'd0 || m_tdata !== '0) begin
            miscompares++;
            $display("FAIL %s_state: got drop=%0d state=%0d data=%h required 0", name, drop_count, dbg_state, m_tdata);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_req_q.delete();
        resp_q.delete();
        model_ptr    = 0;
        misses_total = 0;
        req_pend     = 1'b0;
        m01_wait_cnt = 0;
        for (int c = 0; c < NCH; c++) first_beat[c] = 1'b1;
    endtask

    task automatic set_knobs(int st, int ml, int rd, int tm, bit h5);
        stall_pct = st; m01_low_pct = ml; resp_delay_pct = rd; tready_mode = tm; m01_hold5 = h5;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_inputs();
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_single_hit();
        int start;
        set_knobs(0, 0, 0, 0, 1'b0);
        add_packet(2, 3, IDW'(5), 1'b0);
        build_model();
        start = cyc;
        first_out_cyc = -1;
        run(200, -1, "single_hit");
        // IDLE, REQ, WAIT cycles before the first forwarded beat
        vectors++;
        if (first_out_cyc - start !== 3) begin
            miscompares++;
            $display("FAIL single_hit_latency: got %0d required 3", first_out_cyc - start);
        end
        end_check("single_hit");
    endtask

    task automatic test_round_robin();
        set_knobs(0, 0, 0, 0, 1'b0);
        add_packet(0, 2, IDW'(8), 1'b0);
        add_packet(1, 2, IDW'(9), 1'b0);
        add_packet(3, 2, IDW'(12), 1'b0);
        build_model();
        run(300, -1, "round_robin");
        end_check("round_robin");
    endtask

    task automatic test_miss();
        set_knobs(0, 0, 0, 0, 1'b0);
        add_packet(1, 4, IDW'(7), 1'b0);
        build_model();
        run(200, -1, "miss");
        end_check("miss");
    endtask

    task automatic test_backpressure();
        set_knobs(25, 0, 0, 1, 1'b1);
        add_packet(0, 5, IDW'(20), 1'b0);
        add_packet(2, 4, IDW'(33), 1'b0);
        add_packet(0, 3, IDW'(17), 1'b0);
        build_model();
        run(600, -1, "backpressure");
        end_check("backpressure");
    endtask

    task automatic test_random();
        set_knobs(30, 30, 40, 2, 1'b0);
        for (int i = 0; i < 16; i++) begin
            add_packet($urandom_range(NCH - 1), $urandom_range(5, 1), IDW'($urandom), 1'b0);
        end
        build_model();
        run(3000, -1, "random");
        end_check("random");
    endtask

    task automatic test_reset_mid_packet();
        set_knobs(0, 0, 0, 0, 1'b0);
        add_packet(1, 4, IDW'(9), 1'b1);
        build_model();
        run(200, beats_seen + 1, "reset_mid");
        drive_inputs();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        build_model();
        run(200, -1, "reset_mid_after");
        end_check("reset_mid_after");
    endtask

    task automatic test_saturate();
        set_knobs(0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            add_packet(i % NCH, 1, {IDW'($urandom_range(4000)), 2'b11}, 1'b0);
        end
        build_model();
        run(600, -1, "saturate");
        end_check("saturate");
    endtask

    initial begin
        tvalid = '0; tlast = '0; tdata = '0; tkeep = '0; conn_id = '0;
        m01_ready = 1'b0; s01_valid = 1'b0; s01_hit = 1'b0;
        s01_mac = '0; s01_ip = '0; s01_port = '0; m_tready = 1'b0;
        valid_drv = '0;
        test_reset();
        test_single_hit();
        test_round_robin();
        test_miss();
        test_backpressure();
        test_random();
        test_reset_mid_packet();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
